// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The controller side (master) launches a compare; the comparator side
// (slave) reports busy/done, the decision flags and the per-bit diff mask.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             result;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [WIDTH-1:0] diff_mask;

    modport master (
        output start,
        output a,
        output b,
        output mode,
        input  busy,
        input  done,
        input  result,
        input  eq,
        input  lt,
        input  gt,
        input  diff_mask
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  mode,
        output busy,
        output done,
        output result,
        output eq,
        output lt,
        output gt,
        output diff_mask
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// A start in IDLE captures the operands and mode; SCAN walks the bits from
// WIDTH-1 down to 0; DONE pulses done for one cycle with the flags valid.
// The per-bit decision is registered (stop_q) and applied on the following
// SCAN cycle, so the flag update on entry to DONE comes straight from flops
// rather than from the operand bit multiplexer.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 5,
    parameter bit SIGNED     = 1'b0,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic                          clk,
    input logic                          reset,
    serial_magnitude_comparator_if.slave cmp
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_GT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [1:0]       mode_q,      mode_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             found_q,     found_d;
    logic             dec_gt_q,    dec_gt_d;
    logic             stop_q,      stop_d;
    logic             eq_q,        eq_d;
    logic             lt_q,        lt_d;
    logic             gt_q,        gt_d;
    logic             result_q,    result_d;
    logic [WIDTH-1:0] diff_mask_q, diff_mask_d;

    logic bit_a;
    logic bit_b;
    logic bit_diff;
    logic bit_gt;
    logic fin_eq;
    logic fin_lt;
    logic fin_gt;

    // Examine the current bit and work out which operand it favours.
    always_comb begin
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        bit_diff = bit_a ^ bit_b;
        if (SIGNED && (idx_q == IDX_TOP)) begin
            bit_gt = bit_b;
        end else begin
            bit_gt = bit_a;
        end
    end

    // Final flags from the recorded first difference (equal if none).
    always_comb begin
        fin_eq = ~found_q;
        fin_gt = found_q & dec_gt_q;
        fin_lt = found_q & ~dec_gt_q;
    end

    // Next-state and datapath updates for the IDLE/SCAN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        found_d     = found_q;
        dec_gt_d    = dec_gt_q;
        stop_d      = stop_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        result_d    = result_q;
        diff_mask_d = diff_mask_q;

        case (state_q)
            ST_IDLE: begin
                if (cmp.start) begin
                    a_d         = cmp.a;
                    b_d         = cmp.b;
                    mode_d      = cmp.mode;
                    diff_mask_d = cmp.a ^ cmp.b;
                    idx_d       = IDX_TOP;
                    found_d     = 1'b0;
                    dec_gt_d    = 1'b0;
                    stop_d      = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                    gt_d        = 1'b0;
                    result_d    = 1'b0;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (stop_q) begin
                    eq_d  = fin_eq;
                    lt_d  = fin_lt;
                    gt_d  = fin_gt;
                    case (mode_q)
                        MODE_EQ: result_d = fin_eq;
                        MODE_NE: result_d = ~fin_eq;
                        MODE_LT: result_d = fin_lt;
                        MODE_GT: result_d = fin_gt;
                        default: result_d = 1'b0;
                    endcase
                    stop_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    if (bit_diff && !found_q) begin
                        found_d  = 1'b1;
                        dec_gt_d = bit_gt;
                    end
                    if ((bit_diff && EARLY_EXIT) || (idx_q == IDX_ZERO)) begin
                        stop_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_ONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            dec_gt_q    <= 1'b0;
            stop_q      <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            result_q    <= 1'b0;
            diff_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            dec_gt_q    <= dec_gt_d;
            stop_q      <= stop_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            result_q    <= result_d;
            diff_mask_q <= diff_mask_d;
        end
    end

    // Status and held results straight from state and flops.
    always_comb begin
        cmp.busy      = (state_q != ST_IDLE);
        cmp.done      = (state_q == ST_DONE);
        cmp.result    = result_q;
        cmp.eq        = eq_q;
        cmp.lt        = lt_q;
        cmp.gt        = gt_q;
        cmp.diff_mask = diff_mask_q;
    end

endmodule
